spi_master_param: RTL and testbench
===================================

// Module: spi_master_param
// PURPOSE
//  Parametrised SPI master; successor to the fixed 16-bit mode-0 SPI core behind the APB-SPI bridge.
//  Adds configurable word width, programmable SCLK divider, all four CPOL/CPHA modes,
//  multiple one-hot chip selects and a one-cycle done pulse.
//  Driven by the APB register slave; one transfer per start, MSB first, full duplex.
// PARAMETERS
//  DATA_W  16  bits per transfer (2..32)
//  CS_N    4   number of chip-select lines (1..8)
//  DIV_W   8   width of clk_div; half-period = clk_div+1 clk cycles
// PORTS
//  clk          in   1                 system clock; single clock domain
//  reset        in   1                 synchronous, active-high reset
//  start        in   1                 transfer request; sampled only in IDLE
//  datain       in   DATA_W            TX word; latched on accepted start
//  cs_sel       in   $clog2(CS_N)|1    target slave index; latched on start
//  cpol         in   1                 SCLK idle level; latched on start
//  cpha         in   1                 0: sample leading edge; 1: sample trailing edge
//  clk_div      in   DIV_W             half-period minus one; latched on start
//  master_data  in   1                 MISO from slave
//  dataout      out  DATA_W            last received word
//  busy         out  1                 transfer in progress
//  done         out  1                 one-cycle pulse: transfer complete
//  spi_cs_l     out  CS_N              active-low chip selects, at most one low
//  spi_clk      out  1                 SCLK
//  spi_data     out  1                 MOSI
// BEHAVIOUR
//  Reset (sync, wins over everything): busy=0, done=0, dataout=0, spi_cs_l=all 1, spi_clk=0,
//   spi_data=0, state=IDLE, divider and bit counters cleared. Mid-transfer reset aborts next edge.
//  FSM: IDLE -> LEAD -> XFER -> TRAIL -> IDLE. Each of LEAD and TRAIL lasts one half-period.
//   XFER lasts 2*DATA_W half-periods, each (clk_div_q+1) cycles.
//  Accept: start=1 in IDLE at edge k -> from k+1: busy=1, selected spi_cs_l low, spi_clk=cpol_q.
//   Registers latched at accept: datain, cs_sel, cpol, cpha, clk_div.
//   cpha=0: spi_data=datain[MSB] from k+1.
//  IDLE: spi_clk follows the registered cpol input. spi_data holds its last value.
//  XFER: spi_clk toggles at the end of each half-period. Edge 1 is the leading edge.
//   cpha=0: sample MISO on odd edges; shift MOSI on even edges (not after the last edge).
//   cpha=1: shift MOSI on odd edges (edge 1 drives MSB); sample MISO on even edges.
//   Sampling shifts the receive register left, inserting master_data at the LSB.
//  After edge 2*DATA_W, spi_clk is back at cpol_q; TRAIL holds CS low for one half-period.
//  Completion: busy is high for exactly (2*DATA_W+2)*(clk_div_q+1) cycles.
//   In the first cycle with busy=0: done=1, dataout=received word, spi_cs_l=all 1.
//   dataout holds until the next done.
//  start while busy: ignored, no queuing. start in the done cycle: accepted (state is IDLE).
//  cs_sel>=CS_N: transfer runs normally, no CS line asserted.
//  Changes to cpol/cpha/clk_div/datain during busy: no effect on the current transfer.
//  clk_div=0: SCLK = clk/2. Maximum clk_div gives a half-period of 2^DIV_W cycles.
//  Counter widths: bit counter $clog2(2*DATA_W+1); divider counter DIV_W bits, no wrap.
// STRUCTURE
//  Package spi_pkg holds:
//   - FSM state encoding (IDLE/LEAD/XFER/TRAIL, 2 bits)
//   - mode constants SPI_MODE0..3 = {cpol,cpha}
//   - default DATA_W/CS_N/DIV_W
//  Sub-module spi_clkgen: half-period divider. Inputs: en, clk_div_q. Output: one-cycle
//   edge_stb at each half-period boundary. The FSM, shift registers and CS decode stay in the top.
// TESTING
//  1. Mode0, DATA_W=16, clk_div=0, datain=16'hA5C3, MISO looped to MOSI
//     -> dataout=16'hA5C3, busy 34 cycles, one done pulse, spi_cs_l=4'b1110 (cs_sel=0).
//  2. Mode3, clk_div=3, cs_sel=2, slave model returns 16'h1234
//     -> dataout=16'h1234, spi_clk idles 1, 8 cycles per bit, busy 136 cycles, spi_cs_l=4'b1011.
//  3. Modes 1 and 2 with slave model: MOSI 16'h8001 received by slave, MISO 16'h7FFE
//     -> dataout=16'h7FFE; sample/shift edges match cpha.
//  4. Pulse start 5 cycles into a transfer with datain=16'hFFFF
//     -> ignored; original word sent, single done pulse. Then start in the done cycle
//     -> second transfer begins next cycle.
//  5. Assert reset mid-XFER (bit 7)
//     -> next cycle busy=0, spi_cs_l=all 1, spi_clk=0, dataout=0, no done.
//  6. cs_sel=5 with CS_N=4
//     -> spi_cs_l stays 4'b1111 and SCLK still toggles 32 edges; done pulses.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI master: FSM states, mode codes, defaults.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_XFER  = 2'd2,
        ST_TRAIL = 2'd3
    } spi_state_t;

    // Mode codes are {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam int unsigned SPI_DATA_W_DEF = 16;
    localparam int unsigned SPI_CS_N_DEF   = 4;
    localparam int unsigned SPI_DIV_W_DEF  = 8;

endpackage

// File: rtl/spi_clkgen.sv
// Half-period divider: emits a one-cycle strobe every clk_div_q+1 cycles while enabled.
module spi_clkgen
    import spi_pkg::*;
#(
    parameter int unsigned DIV_W = SPI_DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] clk_div_q,
    output logic             edge_stb
);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || !en || (r_cnt == clk_div_q))
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign edge_stb = en && (r_cnt == clk_div_q);

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable width, SCLK divider, CPOL/CPHA, one-hot active-low CS.
module spi_master_param
    import spi_pkg::*;
#(
    parameter  int unsigned DATA_W = SPI_DATA_W_DEF,
    parameter  int unsigned CS_N   = SPI_CS_N_DEF,
    parameter  int unsigned DIV_W  = SPI_DIV_W_DEF,
    localparam int unsigned CS_W   = $clog2(CS_N) | 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] datain,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              master_data,
    output logic [DATA_W-1:0] dataout,
    output logic              busy,
    output logic              done,
    output logic [CS_N-1:0]   spi_cs_l,
    output logic              spi_clk,
    output logic              spi_data
);

    localparam int unsigned    EW      = $clog2(2*DATA_W+1);
    localparam logic [EW-1:0]  LAST_M1 = EW'(2*DATA_W-1);

    spi_state_t        r_state;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [EW-1:0]     r_edge;
    logic              r_cpol_q;
    logic              r_cpha_q;
    logic [DIV_W-1:0]  r_div_q;

    logic              w_edge_stb;
    logic              w_sample;
    logic              w_last;
    logic [CS_N-1:0]   w_cs_dec;

    spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk       (clk),
        .reset     (reset),
        .en        (r_state != ST_IDLE),
        .clk_div_q (r_div_q),
        .edge_stb  (w_edge_stb)
    );

    // Edge about to complete is r_edge+1; it is odd when r_edge is even.
    assign w_sample = r_cpha_q ? r_edge[0] : ~r_edge[0];
    assign w_last   = (r_edge == LAST_M1);

    always_comb begin
        w_cs_dec = '1;
        for (int unsigned i = 0; i < CS_N; i++)
            if (cs_sel == CS_W'(i)) w_cs_dec[i] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_tx     <= '0;
            r_rx     <= '0;
            r_edge   <= '0;
            r_cpol_q <= 1'b0;
            r_cpha_q <= 1'b0;
            r_div_q  <= '0;
            dataout  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            spi_cs_l <= '1;
            spi_clk  <= 1'b0;
            spi_data <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    spi_clk <= cpol;
                    if (start) begin
                        r_state  <= ST_LEAD;
                        busy     <= 1'b1;
                        spi_cs_l <= w_cs_dec;
                        r_cpol_q <= cpol;
                        r_cpha_q <= cpha;
                        r_div_q  <= clk_div;
                        r_edge   <= '0;
                        r_rx     <= '0;
                        // cpha=0 presents the MSB now, so the shifter starts one bit ahead
                        if (!cpha) begin
                            spi_data <= datain[DATA_W-1];
                            r_tx     <= {datain[DATA_W-2:0], 1'b0};
                        end else begin
                            r_tx     <= datain;
                        end
                    end
                end
                ST_LEAD: begin
                    if (w_edge_stb) r_state <= ST_XFER;
                end
                ST_XFER: begin
                    if (w_edge_stb) begin
                        spi_clk <= ~spi_clk;
                        r_edge  <= r_edge + 1'b1;
                        if (w_sample) begin
                            r_rx <= {r_rx[DATA_W-2:0], master_data};
                        end else if (!w_last) begin
                            spi_data <= r_tx[DATA_W-1];
                            r_tx     <= {r_tx[DATA_W-2:0], 1'b0};
                        end
                        if (w_last) r_state <= ST_TRAIL;
                    end
                end
                ST_TRAIL: begin
                    if (w_edge_stb) begin
                        r_state  <= ST_IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        dataout  <= r_rx;
                        spi_cs_l <= '1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench: timing-level reference model, behavioural SPI slave, directed + random transfers.
module tb_spi_master_param;

    localparam int W  = 16;
    localparam int CN = 4;

    logic        clk = 1'b0;
    logic        reset, start, cpol, cpha, loop;
    logic [15:0] datain, s_word;
    logic [2:0]  cs_sel;
    logic [7:0]  clk_div;
    logic        s_miso;
    wire         master_data = loop ? spi_data : s_miso;
    logic [15:0] dataout;
    logic        busy, done, spi_clk, spi_data;
    logic [3:0]  spi_cs_l;

    int checks = 0;
    int errors = 0;

    spi_master_param #(.DATA_W(16), .CS_N(4), .DIV_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .datain(datain), .cs_sel(cs_sel),
        .cpol(cpol), .cpha(cpha), .clk_div(clk_div), .master_data(master_data),
        .dataout(dataout), .busy(busy), .done(done), .spi_cs_l(spi_cs_l),
        .spi_clk(spi_clk), .spi_data(spi_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what each output must be, from elapsed cycles since accept.
    logic        m_busy = 0, m_done = 0, m_sclk = 0, m_cpol_q = 0, m_cpha_q = 0;
    logic [15:0] m_dataout = '0, m_rx_exp = '0, m_tx = '0;
    logic [3:0]  m_cs = '1;
    int          m_j = 0, m_N = 0, m_P = 1, m_h, m_e;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_dataout = '0; m_cs = '1; m_sclk = 0; m_j = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                if (m_j == m_N) begin
                    m_busy = 0; m_done = 1; m_dataout = m_rx_exp; m_cs = '1; m_sclk = m_cpol_q;
                end else begin
                    m_j++;
                    m_h = (m_j - 1) / m_P;
                    m_e = (m_h < 1) ? 0 : ((m_h - 1 > 2*W) ? 2*W : m_h - 1);
                    m_sclk = m_cpol_q ^ m_e[0];
                end
            end else if (start) begin
                m_busy = 1; m_j = 1; m_P = int'(clk_div) + 1; m_N = (2*W + 2) * m_P;
                m_cpol_q = cpol; m_cpha_q = cpha; m_tx = datain;
                m_rx_exp = loop ? datain : s_word;
                m_cs = (cs_sel < CN) ? ~(4'b0001 << cs_sel) : 4'hF;
                m_sclk = cpol;
            end else begin
                m_sclk = cpol;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("cs", 32'(spi_cs_l), 32'(m_cs));
        chk("sclk", 32'(spi_clk), 32'(m_sclk));
        chk("dataout", 32'(dataout), 32'(m_dataout));
        if (m_busy && m_j == 1 && !m_cpha_q)
            chk("mosi_msb", 32'(spi_data), 32'(m_tx[15]));
    end

    // Behavioural slave: counts SCLK edges, samples MOSI / drives MISO per cpha.
    logic        s_prev_busy = 0, s_prev_sclk = 0, s_smp;
    logic [15:0] s_rx = '0, s_tx = '0;
    int          s_e = 0;

    always @(negedge clk) begin
        if (busy && !s_prev_busy) begin
            s_e = 0; s_rx = '0; s_tx = s_word;
            if (!m_cpha_q) s_miso = s_tx[15];
        end else if (busy && spi_clk !== s_prev_sclk) begin
            s_e++;
            s_smp = m_cpha_q ? ~s_e[0] : s_e[0];
            if (s_smp) s_rx = {s_rx[14:0], spi_data};
            else if (m_cpha_q) s_miso = s_tx[15 - (s_e - 1) / 2];
            else if (s_e < 2*W) s_miso = s_tx[15 - s_e / 2];
        end
        if (done) begin
            chk("slave_mosi", 32'(s_rx), 32'(m_tx));
            chk("sclk_edges", 32'(s_e), 32'(2*W));
        end
        s_prev_busy = busy;
        s_prev_sclk = spi_clk;
    end

    task automatic launch(input logic [1:0] mode, input logic [7:0] div, input logic [2:0] sel,
                          input logic [15:0] din, input logic [15:0] sw, input logic lp);
        @(posedge clk); #1;
        {cpol, cpha} = mode; clk_div = div; cs_sel = sel; datain = din; s_word = sw; loop = lp;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int bcyc, output logic [3:0] cs_seen);
        bcyc = 0; cs_seen = '1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (busy) begin
                bcyc++;
                if (bcyc == 1) cs_seen = spi_cs_l;
            end
            if (done) return;
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    int          bc;
    logic [3:0]  cs_s;
    logic [1:0]  rmode;
    logic [7:0]  rdiv;

    initial begin
        reset = 1; start = 0; cpol = 0; cpha = 0; loop = 0; datain = '0; s_word = '0;
        cs_sel = '0; clk_div = '0; s_miso = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("reset_cs", 32'(spi_cs_l), 32'hF);
        chk("reset_dataout", 32'(dataout), 32'h0);

        // 1: mode 0, fastest clock, loopback
        launch(2'b00, 8'd0, 3'd0, 16'hA5C3, 16'h0000, 1'b1);
        wait_done(200, bc, cs_s);
        chk("t1_busy_len", 32'(bc), 32'd34);
        chk("t1_cs", 32'(cs_s), 32'b1110);
        chk("t1_dataout", 32'(dataout), 32'hA5C3);

        // 2: mode 3, divider 3, slave on CS2
        launch(2'b11, 8'd3, 3'd2, 16'h5A5A, 16'h1234, 1'b0);
        wait_done(400, bc, cs_s);
        chk("t2_busy_len", 32'(bc), 32'd136);
        chk("t2_cs", 32'(cs_s), 32'b1011);
        chk("t2_dataout", 32'(dataout), 32'h1234);
        repeat (3) @(negedge clk);
        chk("t2_sclk_idle", 32'(spi_clk), 32'd1);

        // 3: modes 1 and 2
        launch(2'b01, 8'd1, 3'd1, 16'h8001, 16'h7FFE, 1'b0);
        wait_done(400, bc, cs_s);
        chk("t3m1_dataout", 32'(dataout), 32'h7FFE);
        chk("t3m1_slave_rx", 32'(s_rx), 32'h8001);
        launch(2'b10, 8'd2, 3'd3, 16'h8001, 16'h7FFE, 1'b0);
        wait_done(400, bc, cs_s);
        chk("t3m2_dataout", 32'(dataout), 32'h7FFE);
        chk("t3m2_slave_rx", 32'(s_rx), 32'h8001);

        // 4: start during busy ignored, start in done cycle accepted
        launch(2'b00, 8'd1, 3'd0, 16'h3C96, 16'hBEEF, 1'b0);
        repeat (4) @(posedge clk);
        #1 datain = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(400, bc, cs_s);
        chk("t4_dataout", 32'(dataout), 32'hBEEF);
        chk("t4_slave_rx", 32'(s_rx), 32'h3C96);
        datain = 16'h0F0F; s_word = 16'hC001; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("t4_restart_busy", 32'(busy), 32'd1);
        wait_done(400, bc, cs_s);
        chk("t4b_dataout", 32'(dataout), 32'hC001);

        // 5: reset in the middle of the transfer
        launch(2'b00, 8'd1, 3'd1, 16'h1357, 16'h2468, 1'b0);
        for (int n = 0; n < 200 && s_e < 14; n++) @(negedge clk);
        chk("t5_reached_bit7", 32'(s_e >= 14), 32'd1);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_cs", 32'(spi_cs_l), 32'hF);
        chk("t5_sclk", 32'(spi_clk), 32'd0);
        chk("t5_dataout", 32'(dataout), 32'd0);
        chk("t5_done", 32'(done), 32'd0);

        // 6: out-of-range chip select
        launch(2'b00, 8'd0, 3'd5, 16'h6666, 16'h9999, 1'b0);
        wait_done(200, bc, cs_s);
        chk("t6_cs", 32'(cs_s), 32'hF);
        chk("t6_dataout", 32'(dataout), 32'h9999);

        // Maximum divider: half-period of 256 cycles
        launch(2'b10, 8'hFF, 3'd3, 16'hA001, 16'h0FF0, 1'b0);
        wait_done(9000, bc, cs_s);
        chk("max_div_busy_len", 32'(bc), 32'd8704);

        // Random transfers; configuration inputs are scrambled while busy
        for (int i = 0; i < 25; i++) begin
            rmode = 2'($urandom_range(0, 3));
            rdiv  = 8'($urandom_range(0, 3));
            launch(rmode, rdiv, 3'($urandom_range(0, 7)), 16'($urandom),
                   16'($urandom), 1'($urandom_range(0, 1)));
            datain = 16'($urandom); clk_div = 8'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
            wait_done(1000, bc, cs_s);
            chk("rand_busy_len", 32'(bc), 32'(34 * (int'(rdiv) + 1)));
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
